// File: rtl/dac_tx_pkg.sv
// Shared widths, FSM state encoding and DAC power-down mode codes for the
// serial DAC transmitter.
package dac_tx_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;
    localparam int MODE_W  = 2;

    localparam logic [MODE_W-1:0] NORMAL  = 2'b00;
    localparam logic [MODE_W-1:0] PD_1K   = 2'b01;
    localparam logic [MODE_W-1:0] PD_100K = 2'b10;
    localparam logic [MODE_W-1:0] PD_HIZ  = 2'b11;

    typedef enum logic [1:0] {
        REPOSO,
        CARGA,
        TX,
        FIN
    } state_t;

    // Two leading zeros, then the power-down bits, then the sample.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [MODE_W-1:0] mode,
        input logic [DATA_W-1:0] data
    );
        return {2'b00, mode, data};
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Free-running divider: tick is high for one clk cycle every DIV cycles,
// counted from the last synchronous clear.
module dac_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_tx_serial.sv
// 16-bit SPI-style frame transmitter for a serial DAC (SYNC/SCLK/DIN).
// Define DAC_TX_DOUBLE_BUFFER_EN to queue one request received while busy.
module dac_tx_serial
    import dac_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio_tx,
    input  logic [DATA_W-1:0] dato_in,
    input  logic [MODE_W-1:0] modo,
    output logic              SYNC,
    output logic              SCLK,
    output logic              DIN,
    output logic              tx_listo,
    output logic              ocupado,
    output logic              desborde
);

    localparam int         WORD_W   = MODE_W + DATA_W;
    localparam logic [4:0] LAST_BIT = 5'(FRAME_W);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic               sync_q, sync_d;
    logic               din_q, din_d;
    logic               listo_q, listo_d;
    logic               ocupado_q, ocupado_d;
    logic               desborde_q, desborde_d;

    logic               tick;
    logic               clr;
    logic               idle;
    logic               start;
    logic [WORD_W-1:0]  start_word;
    logic [FRAME_W-1:0] start_frame;

    dac_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign idle        = (state_q == REPOSO);
    assign start_frame = build_frame(start_word[WORD_W-1 -: MODE_W], start_word[DATA_W-1:0]);

`ifdef DAC_TX_DOUBLE_BUFFER_EN
    logic              buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              fin_done;
    logic              launch_buf;
    logic              launch_in;

    assign fin_done = (state_q == FIN) && tick;

    // A held request goes out straight from FIN; a new request can refill the slot it frees.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        desborde_d  = desborde_q;
        start       = 1'b0;
        start_word  = {modo, dato_in};
        launch_buf  = buf_valid_q && (idle || fin_done);
        launch_in   = inicio_tx && idle && !buf_valid_q;
        if (launch_buf) begin
            start       = 1'b1;
            start_word  = buf_q;
            buf_valid_d = 1'b0;
        end else if (launch_in) begin
            start = 1'b1;
        end
        if (inicio_tx && !launch_in) begin
            if (!buf_valid_q || launch_buf) begin
                buf_valid_d = 1'b1;
                buf_d       = {modo, dato_in};
            end else begin
                desborde_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end
`else
    always_comb begin
        desborde_d = desborde_q;
        start      = 1'b0;
        start_word = {modo, dato_in};
        if (inicio_tx) begin
            if (idle) begin
                start = 1'b1;
            end else begin
                desborde_d = 1'b1;
            end
        end
    end
`endif

    // NOTE: every always_comb output is defaulted first so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        listo_d   = 1'b0;
        clr       = 1'b0;

        case (state_q)
            REPOSO: begin
                sclk_d = 1'b1;
                din_d  = 1'b0;
            end
            CARGA: begin
                if (tick) begin
                    state_d = TX;
                end
            end
            TX: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = FIN;
                        sclk_d  = 1'b1;
                        din_d   = 1'b0;
                    end else begin
                        // DIN only moves on the rising tick, so it is stable across every fall.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[FRAME_W-2:0], shift_q[FRAME_W-1]};
                        din_d   = shift_q[FRAME_W-2];
                    end
                end
            end
            FIN: begin
                if (tick) begin
                    state_d = REPOSO;
                    listo_d = 1'b1;
                end
            end
        endcase

        if (start) begin
            state_d   = CARGA;
            shift_d   = start_frame;
            din_d     = start_frame[FRAME_W-1];
            sclk_d    = 1'b1;
            bit_cnt_d = '0;
            clr       = 1'b1;
        end

        sync_d    = (state_d == REPOSO) || (state_d == FIN);
        ocupado_d = (state_d != REPOSO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REPOSO;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b1;
            sync_q     <= 1'b1;
            din_q      <= 1'b0;
            listo_q    <= 1'b0;
            ocupado_q  <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            sync_q     <= sync_d;
            din_q      <= din_d;
            listo_q    <= listo_d;
            ocupado_q  <= ocupado_d;
            desborde_q <= desborde_d;
        end
    end

    assign SYNC     = sync_q;
    assign SCLK     = sclk_q;
    assign DIN      = din_q;
    assign tx_listo = listo_q;
    assign ocupado  = ocupado_q;
    assign desborde = desborde_q;

endmodule

// File: tb/tb_dac_tx_serial.sv
// Scoreboard bench: expected frames are queued at issue time and a per-DUT
// monitor rebuilds each frame from DIN at SCLK falling edges.
module tb_dac_tx_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        inicio4 = 1'b0;
    logic [11:0] dato4   = '0;
    logic [1:0]  modo4   = '0;
    logic        sync4, sclk4, din4, listo4, ocup4, desb4;

    logic        inicio2 = 1'b0;
    logic [11:0] dato2   = '0;
    logic [1:0]  modo2   = '0;
    logic        sync2, sclk2, din2, listo2, ocup2, desb2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q4[$];
    logic [15:0] q2[$];
    logic        abort4 = 1'b0;

    always #5 clk = ~clk;

    dac_tx_serial #(.DIV(4)) dut4 (
        .clk(clk), .rst(rst), .inicio_tx(inicio4), .dato_in(dato4), .modo(modo4),
        .SYNC(sync4), .SCLK(sclk4), .DIN(din4),
        .tx_listo(listo4), .ocupado(ocup4), .desborde(desb4)
    );

    dac_tx_serial #(.DIV(2)) dut2 (
        .clk(clk), .rst(rst), .inicio_tx(inicio2), .dato_in(dato2), .modo(modo2),
        .SYNC(sync2), .SCLK(sclk2), .DIN(din2),
        .tx_listo(listo2), .ocupado(ocup2), .desborde(desb2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the DIV=4 instance.
    logic [15:0] sh4;
    int          nb4 = 0;
    logic        ps_sync4 = 1'b1, ps_sclk4 = 1'b1, ps_din4 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            nb4 = 0;
        end else begin
            if (!sync4 && ps_sclk4 && !sclk4) begin
                check("din4_stable_at_fall", din4, ps_din4);
                sh4 = {sh4[14:0], ps_din4};
                nb4++;
            end
            if (!ps_sync4 && sync4) begin
                if (nb4 == 16) begin
                    check("frame4_pending", q4.size() != 0, 1);
                    if (q4.size() != 0) check("frame4", sh4, q4.pop_front());
                end else if (!abort4) begin
                    check("frame4_bits", nb4, 16);
                end
                nb4 = 0;
            end
        end
        ps_sync4 = sync4;
        ps_sclk4 = sclk4;
        ps_din4  = din4;
    end

    // Monitor for the DIV=2 instance.
    logic [15:0] sh2;
    int          nb2 = 0;
    logic        ps_sync2 = 1'b1, ps_sclk2 = 1'b1, ps_din2 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            nb2 = 0;
        end else begin
            if (!sync2 && ps_sclk2 && !sclk2) begin
                check("din2_stable_at_fall", din2, ps_din2);
                sh2 = {sh2[14:0], ps_din2};
                nb2++;
            end
            if (!ps_sync2 && sync2) begin
                if (nb2 == 16) begin
                    check("frame2_pending", q2.size() != 0, 1);
                    if (q2.size() != 0) check("frame2", sh2, q2.pop_front());
                end else begin
                    check("frame2_bits", nb2, 16);
                end
                nb2 = 0;
            end
        end
        ps_sync2 = sync2;
        ps_sclk2 = sclk2;
        ps_din2  = din2;
    end

    // Pulse inicio_tx on dut4 for one cycle (cycle 0); returns at #1 into cycle 1.
    task automatic start4(input logic [11:0] d, input logic [1:0] m, input logic [15:0] exp, input bit push);
        @(posedge clk); #1;
        dato4   = d;
        modo4   = m;
        inicio4 = 1'b1;
        if (push) q4.push_back(exp);
        @(posedge clk); #1;
        inicio4 = 1'b0;
    endtask

    // Watch dut4 from cycle 1 for ncyc cycles; mode selects a mid-frame action.
    task automatic obs4(input int mode, input int ncyc,
                        output int f1, output int f2, output int r1, output int l1, output int ln);
        logic ps = 1'b1;
        f1 = -1; f2 = -1; r1 = -1; l1 = -1; ln = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (ps && !sync4) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
            if (!ps && sync4 && r1 < 0) r1 = k;
            if (listo4) begin
                ln++;
                if (l1 < 0) l1 = k;
            end
            if (k == 1) check("busy_in_cycle1", ocup4, 1);
            case (mode)
                1: if (k == 10) begin
                       dato4 = 12'h000;
                       modo4 = 2'b00;
                   end
                2: if (k == 60) begin
                       rst = 1'b1;
                   end else if (k == 61) begin
                       rst = 1'b0;
                       check("abort_sync_sclk_busy", {sync4, sclk4, ocup4}, 3'b110);
                   end
                3: if (k == 40) begin
                       check("desborde_before_second", desb4, 0);
                       dato4   = 12'h7E7;
                       modo4   = 2'b01;
                       inicio4 = 1'b1;
`ifdef DAC_TX_DOUBLE_BUFFER_EN
                       q4.push_back(16'h17E7);
`endif
                   end else if (k == 41) begin
                       inicio4 = 1'b0;
                       dato4   = 12'h000;
`ifdef DAC_TX_DOUBLE_BUFFER_EN
                       check("desborde_after_second", desb4, 0);
`else
                       check("desborde_after_second", desb4, 1);
`endif
                   end
                default: ;
            endcase
            ps = sync4;
            @(posedge clk); #1;
        end
    endtask

    int f1, f2, r1, l1, ln;
    int kl, kf1, kf2;
    logic ps2;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outputs4", {sync4, sclk4, din4, listo4, ocup4, desb4}, 6'b110000);
        check("reset_outputs2", {sync2, sclk2, din2, listo2, ocup2, desb2}, 6'b110000);
        repeat (4) @(posedge clk);

        // Basic frame with exact SYNC / tx_listo timing.
        start4(12'hA5C, 2'b00, 16'h0A5C, 1'b1);
        obs4(0, 160, f1, f2, r1, l1, ln);
        check("t1_sync_fall_cycle", f1, 1);
        check("t1_sync_rise_cycle", r1, 133);
        check("t1_listo_cycle", l1, 137);
        check("t1_listo_count", ln, 1);
        check("t1_idle_after", ocup4, 0);

        // All-ones sample in HiZ mode; inputs change mid-frame.
        start4(12'hFFF, 2'b11, 16'h3FFF, 1'b1);
        obs4(1, 160, f1, f2, r1, l1, ln);
        check("t2_listo_cycle", l1, 137);
        check("t2_listo_count", ln, 1);

        // Reset in cycle 60 aborts the frame silently.
        abort4 = 1'b1;
        start4(12'h123, 2'b01, 16'h0000, 1'b0);
        obs4(2, 200, f1, f2, r1, l1, ln);
        check("t3_no_listo", ln, 0);
        check("t3_desborde_clear", desb4, 0);
        abort4 = 1'b0;

        // Second request in cycle 40 while busy.
        start4(12'h321, 2'b10, 16'h2321, 1'b1);
        obs4(3, 300, f1, f2, r1, l1, ln);
        check("t4_first_listo", l1, 137);
`ifdef DAC_TX_DOUBLE_BUFFER_EN
        check("t4_second_sync_fall", f2, 137);
        check("t4_listo_count", ln, 2);
        check("t4_desborde_final", desb4, 0);
`else
        check("t4_second_sync_fall", f2, -1);
        check("t4_listo_count", ln, 1);
        check("t4_desborde_final", desb4, 1);
`endif

        // DIV=2: restart in the tx_listo cycle.
        @(posedge clk); #1;
        dato2   = 12'h5A5;
        modo2   = 2'b00;
        inicio2 = 1'b1;
        q2.push_back(16'h05A5);
        @(posedge clk); #1;
        inicio2 = 1'b0;
        kl = -1;
        for (int k = 1; k <= 120 && kl < 0; k++) begin
            if (listo2) kl = k;
            else begin
                @(posedge clk); #1;
            end
        end
        check("t5_listo_cycle", kl, 69);
        if (kl > 0) begin
            dato2   = 12'h0F0;
            modo2   = 2'b01;
            inicio2 = 1'b1;
            q2.push_back(16'h10F0);
            @(posedge clk); #1;
            inicio2 = 1'b0;
            check("t5_restart_sync_low", sync2, 0);
            kf1 = -1; kf2 = -1;
            ps2 = sclk2;
            for (int k = 1; k <= 40; k++) begin
                if (ps2 && !sclk2) begin
                    if (kf1 < 0) kf1 = k;
                    else if (kf2 < 0) kf2 = k;
                end
                ps2 = sclk2;
                @(posedge clk); #1;
            end
            check("t5_first_sclk_fall", kf1, 5);
            check("t5_sclk_period", kf2 - kf1, 4);
            repeat (60) @(posedge clk);
            #1;
            check("t5_idle_after", ocup2, 0);
        end

        repeat (5) @(posedge clk);
        check("q4_drained", q4.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
